ov7670_config_seq: RTL and testbench

Sequencer that walks the OV7670 register configuration ROM from address 0, decodes each 16-bit entry as {register, value}, and issues one write per entry to the SCCB master. Entry 16'hFFF0 inserts a fixed settle delay; 16'hFFFF ends the sequence. It sits between the camera top level, which supplies `start`, the synchronous config ROM and the SCCB write engine. It flags completion so capture logic can be released.

---
 rtl/ov7670_config_seq_if.sv | 23 ++
 rtl/ov7670_config_seq.sv | 189 ++++++++++++++++++
 tb/tb_ov7670_config_seq.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ov7670_config_seq_if.sv
// ROM and SCCB write-engine signals shared between the config sequencer (master)
// and the ROM / SCCB master pair (slave).
`timescale 1ns/1ps
interface ov7670_config_seq_if;
  logic [7:0]  rom_addr;
  logic [15:0] rom_dout;
  logic        sccb_start;
  logic [7:0]  sccb_reg;
  logic [7:0]  sccb_val;
  logic        sccb_ready;
  logic        sccb_done;
  logic        sccb_nack;

  modport master (
    output rom_addr, sccb_start, sccb_reg, sccb_val,
    input  rom_dout, sccb_ready, sccb_done, sccb_nack
  );

  modport slave (
    input  rom_addr, sccb_start, sccb_reg, sccb_val,
    output rom_dout, sccb_ready, sccb_done, sccb_nack
  );
endinterface

// File: rtl/ov7670_config_seq.sv
// OV7670 register-configuration sequencer: walks the config ROM and issues one SCCB
// write per {register, value} entry. Define OV7670_CFG_RETRY_EN for NACK retry/ERROR.
`timescale 1ns/1ps
module ov7670_config_seq #(
  parameter int DELAY_CYCLES = 240000,
  parameter int MAX_RETRY    = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  ov7670_config_seq_if.master        bus,
  output logic                       busy,
  output logic                       done
`ifdef OV7670_CFG_RETRY_EN
  ,
  output logic                       error
`endif
);

  localparam int              DW          = $clog2(DELAY_CYCLES + 1);
  localparam logic [DW-1:0]   DELAY_LOAD  = DW'(DELAY_CYCLES - 1);
  localparam logic [15:0]     ENTRY_END   = 16'hFFFF;
  localparam logic [15:0]     ENTRY_DELAY = 16'hFFF0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_SEND,
    S_WAIT,
    S_DELAY,
    S_DONE
`ifdef OV7670_CFG_RETRY_EN
    ,
    S_ERROR
`endif
  } state_e;

  state_e        state_q;
  logic [7:0]    rom_addr_q;
  logic          sccb_start_q;
  logic [7:0]    sccb_reg_q;
  logic [7:0]    sccb_val_q;
  logic          busy_q;
  logic          done_q;
  logic [DW-1:0] delay_q;
  logic          last_entry;

  assign last_entry = (rom_addr_q == 8'hFF);

`ifdef OV7670_CFG_RETRY_EN
  localparam int            RW          = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] MAX_RETRY_C = RW'(MAX_RETRY);

  logic [RW-1:0] retry_q;
  logic          error_q;

  assign error = error_q;
`else
  logic unused_nack;
  assign unused_nack = bus.sccb_nack & (MAX_RETRY > 0);
`endif

  // NOTE: every state register below uses <= so all of them see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rom_addr_q   <= 8'h00;
      sccb_start_q <= 1'b0;
      sccb_reg_q   <= 8'h00;
      sccb_val_q   <= 8'h00;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      delay_q      <= '0;
`ifdef OV7670_CFG_RETRY_EN
      retry_q      <= '0;
      error_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            rom_addr_q <= 8'h00;
            busy_q     <= 1'b1;
            state_q    <= S_FETCH;
          end
        end

        // ROM output lands one cycle after the address; also a fresh entry starts here.
        S_FETCH: begin
`ifdef OV7670_CFG_RETRY_EN
          retry_q <= '0;
`endif
          state_q <= S_DECODE;
        end

        S_DECODE: begin
          if (bus.rom_dout == ENTRY_END) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (bus.rom_dout == ENTRY_DELAY) begin
            delay_q <= DELAY_LOAD;
            state_q <= S_DELAY;
          end else begin
            sccb_reg_q   <= bus.rom_dout[15:8];
            sccb_val_q   <= bus.rom_dout[7:0];
            sccb_start_q <= 1'b1;
            state_q      <= S_SEND;
          end
        end

        S_SEND: begin
          if (bus.sccb_ready) begin
            sccb_start_q <= 1'b0;
            state_q      <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (bus.sccb_done) begin
`ifdef OV7670_CFG_RETRY_EN
            if (bus.sccb_nack && (retry_q == MAX_RETRY_C)) begin
              busy_q  <= 1'b0;
              error_q <= 1'b1;
              state_q <= S_ERROR;
            end else if (bus.sccb_nack) begin
              retry_q      <= retry_q + RW'(1);
              sccb_start_q <= 1'b1;
              state_q      <= S_SEND;
            end else
`endif
            if (last_entry) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              rom_addr_q <= rom_addr_q + 8'd1;
              state_q    <= S_FETCH;
            end
          end
        end

        S_DELAY: begin
          if (delay_q != '0) begin
            delay_q <= delay_q - DW'(1);
          end else if (last_entry) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            rom_addr_q <= rom_addr_q + 8'd1;
            state_q    <= S_FETCH;
          end
        end

        S_DONE: begin
          if (start) begin
            rom_addr_q <= 8'h00;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            state_q    <= S_FETCH;
          end
        end

`ifdef OV7670_CFG_RETRY_EN
        S_ERROR: begin
          if (start) begin
            rom_addr_q <= 8'h00;
            busy_q     <= 1'b1;
            error_q    <= 1'b0;
            state_q    <= S_FETCH;
          end
        end
`endif

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.rom_addr   = rom_addr_q;
  assign bus.sccb_start = sccb_start_q;
  assign bus.sccb_reg   = sccb_reg_q;
  assign bus.sccb_val   = sccb_val_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_ov7670_config_seq.sv
// Directed bench for ov7670_config_seq: registered ROM model plus an SCCB master
// model that answers 20 cycles after each accepted write.
`timescale 1ns/1ps
module tb_ov7670_config_seq;
  localparam int DELAY_CYCLES = 16;
  localparam int MAX_RETRY    = 2;
  localparam int DONE_LAT     = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy;
  logic done;
  logic err_sig;

  ov7670_config_seq_if bus ();

`ifdef OV7670_CFG_RETRY_EN
  logic error;
  assign err_sig = error;
`else
  assign err_sig = 1'b0;
`endif

  ov7670_config_seq #(
    .DELAY_CYCLES (DELAY_CYCLES),
    .MAX_RETRY    (MAX_RETRY)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
`ifdef OV7670_CFG_RETRY_EN
    ,
    .error (error)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous config ROM.
  logic [15:0] rom [256];
  always @(posedge clk) bus.rom_dout <= rom[bus.rom_addr];

  // SCCB master model: accepts when idle, answers DONE_LAT cycles later.
  logic        ready_en  = 1'b1;
  logic [31:0] nack_mask = '0;
  logic        m_busy    = 1'b0;
  int          m_cnt     = 0;
  int          acc_cnt   = 0;
  int          cycle     = 0;
  logic [7:0]  acc_reg [512];
  logic [7:0]  acc_val [512];
  int          acc_cyc [512];

  assign bus.sccb_ready = ready_en && !m_busy;

  always @(posedge clk) cycle <= cycle + 1;

  always @(posedge clk) begin
    bus.sccb_done <= 1'b0;
    bus.sccb_nack <= 1'b0;
    if (rst) begin
      m_busy  <= 1'b0;
      m_cnt   <= 0;
      acc_cnt <= 0;
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        bus.sccb_done <= 1'b1;
        bus.sccb_nack <= nack_mask[5'(acc_cnt - 1)];
        m_busy        <= 1'b0;
      end
      m_cnt <= m_cnt - 1;
    end else if (bus.sccb_start && bus.sccb_ready) begin
      m_busy <= 1'b1;
      m_cnt  <= DONE_LAT;
      if (acc_cnt < 512) begin
        acc_reg[acc_cnt] <= bus.sccb_reg;
        acc_val[acc_cnt] <= bus.sccb_val;
        acc_cyc[acc_cnt] <= cycle;
      end
      acc_cnt <= acc_cnt + 1;
    end
  end

  // Address wrap watcher.
  logic       wrap_seen = 1'b0;
  logic [7:0] prev_addr = 8'h00;
  always @(negedge clk) begin
    if (rst) wrap_seen <= 1'b0;
    else if (busy && prev_addr == 8'hFF && bus.rom_addr == 8'h00) wrap_seen <= 1'b1;
    prev_addr <= bus.rom_addr;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    int n = 0;
    while (!(done === 1'b1 || err_sig === 1'b1) && n < budget) begin
      tick(1);
      n++;
    end
    check({tag, "_timeout"}, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_acc(input string tag, input int count, input int budget);
    int n = 0;
    while (acc_cnt < count && n < budget) begin
      tick(1);
      n++;
    end
    check({tag, "_timeout"}, 32'(n < budget), 32'd1);
  endtask

  task automatic load_plan_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    rom[0] = 16'h1280;
    rom[1] = 16'hFFF0;
    rom[2] = 16'h1204;
  endtask

  // Accept-to-accept spacing across the FFF0 entry:
  // 20 done latency + 1 advance + 2 fetch/decode + 16 delay + 3 fetch/decode/send.
  localparam int GAP_DELAY = DONE_LAT + 1 + 2 + DELAY_CYCLES + 3;

  initial begin
    logic stable;
    load_plan_rom();

    // Reset state.
    do_reset();
    check("rst_addr",  32'(bus.rom_addr),   32'h00);
    check("rst_start", 32'(bus.sccb_start), 32'h0);
    check("rst_reg",   32'(bus.sccb_reg),   32'h00);
    check("rst_val",   32'(bus.sccb_val),   32'h00);
    check("rst_busy",  32'(busy),           32'h0);
    check("rst_done",  32'(done),           32'h0);

    // Nominal sequence with latency to the first write.
    pulse_start();
    check("t1_busy_after_start", 32'(busy), 32'h1);
    tick(1);
    check("t1_no_start_decode", 32'(bus.sccb_start), 32'h0);
    tick(1);
    check("t1_start_lat3", 32'(bus.sccb_start), 32'h1);
    check("t1_send_reg",   32'(bus.sccb_reg),   32'h12);
    check("t1_send_val",   32'(bus.sccb_val),   32'h80);
    wait_end("t1_end", 2000);
    check("t1_acc_cnt", 32'(acc_cnt), 32'd2);
    check("t1_w0", {16'h0, acc_reg[0], acc_val[0]}, 32'h1280);
    check("t1_w1", {16'h0, acc_reg[1], acc_val[1]}, 32'h1204);
    check("t1_delay_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'(GAP_DELAY));
    check("t1_end_addr", 32'(bus.rom_addr), 32'h03);
    check("t1_done", 32'(done), 32'h1);
    check("t1_busy_low", 32'(busy), 32'h0);

    // Restart from DONE replays from address 0.
    pulse_start();
    check("t1r_done_clr", 32'(done), 32'h0);
    check("t1r_busy", 32'(busy), 32'h1);
    check("t1r_addr0", 32'(bus.rom_addr), 32'h00);
    wait_end("t1r_end", 2000);
    check("t1r_acc_cnt", 32'(acc_cnt), 32'd4);
    check("t1r_w2", {16'h0, acc_reg[2], acc_val[2]}, 32'h1280);

    // start pulsed while busy (inside DELAY) is ignored.
    do_reset();
    pulse_start();
    wait_acc("t2_acc", 1, 200);
    tick(25);
    pulse_start();
    wait_end("t2_end", 2000);
    check("t2_acc_cnt", 32'(acc_cnt), 32'd2);
    check("t2_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'(GAP_DELAY));
    check("t2_w1", {16'h0, acc_reg[1], acc_val[1]}, 32'h1204);
    check("t2_end_addr", 32'(bus.rom_addr), 32'h03);

    // Back-pressure: held in SEND for 50 cycles.
    do_reset();
    ready_en = 1'b0;
    pulse_start();
    tick(2);
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (!(bus.sccb_start === 1'b1 && bus.sccb_reg === 8'h12 && bus.sccb_val === 8'h80))
        stable = 1'b0;
      tick(1);
    end
    check("t3_stable", 32'(stable), 32'h1);
    check("t3_no_acc", 32'(acc_cnt), 32'd0);
    ready_en = 1'b1;
    tick(1);
    check("t3_one_acc", 32'(acc_cnt), 32'd1);
    check("t3_start_drop", 32'(bus.sccb_start), 32'h0);
    wait_end("t3_end", 2000);
    check("t3_acc_total", 32'(acc_cnt), 32'd2);

    // Reset five cycles into WAIT.
    do_reset();
    pulse_start();
    wait_acc("t4_acc", 1, 200);
    tick(4);
    rst = 1'b1;
    tick(1);
    check("t4_addr",  32'(bus.rom_addr),   32'h00);
    check("t4_start", 32'(bus.sccb_start), 32'h0);
    check("t4_reg",   32'(bus.sccb_reg),   32'h00);
    check("t4_val",   32'(bus.sccb_val),   32'h00);
    check("t4_busy",  32'(busy),           32'h0);
    check("t4_done",  32'(done),           32'h0);
    tick(1);
    rst = 1'b0;
    tick(5);
    check("t4_idle_no_start", 32'(bus.sccb_start), 32'h0);
    pulse_start();
    wait_end("t4_end", 2000);
    check("t4_replay_cnt", 32'(acc_cnt), 32'd2);
    check("t4_replay_w0", {16'h0, acc_reg[0], acc_val[0]}, 32'h1280);

    // Full 256-entry ROM without a terminator.
    for (int i = 0; i < 256; i++) rom[i] = {8'(i), ~8'(i)};
    do_reset();
    pulse_start();
    wait_end("t5_end", 9000);
    check("t5_acc_cnt", 32'(acc_cnt), 32'd256);
    check("t5_w7",   {16'h0, acc_reg[7],   acc_val[7]},   32'h07F8);
    check("t5_w255", {16'h0, acc_reg[255], acc_val[255]}, 32'hFF00);
    check("t5_nowrap", 32'(wrap_seen), 32'h0);
    check("t5_addr", 32'(bus.rom_addr), 32'hFF);
    check("t5_done", 32'(done), 32'h1);

`ifdef OV7670_CFG_RETRY_EN
    // NACK on the first attempt of entry 2, ACK on the retry.
    load_plan_rom();
    nack_mask = 32'b010;
    do_reset();
    pulse_start();
    wait_end("t6_end", 2000);
    check("t6_acc_cnt", 32'(acc_cnt), 32'd3);
    check("t6_w1", {16'h0, acc_reg[1], acc_val[1]}, 32'h1204);
    check("t6_w2", {16'h0, acc_reg[2], acc_val[2]}, 32'h1204);
    check("t6_error", 32'(error), 32'h0);
    check("t6_done", 32'(done), 32'h1);

    // NACK on every attempt: three sends, then ERROR.
    nack_mask = 32'b111;
    do_reset();
    pulse_start();
    wait_end("t7_end", 2000);
    check("t7_error", 32'(error), 32'h1);
    check("t7_busy", 32'(busy), 32'h0);
    check("t7_done", 32'(done), 32'h0);
    check("t7_acc_cnt", 32'(acc_cnt), 32'd3);
    check("t7_addr", 32'(bus.rom_addr), 32'h00);
    pulse_start();
    check("t7r_error_clr", 32'(error), 32'h0);
    check("t7r_busy", 32'(busy), 32'h1);
    wait_end("t7r_end", 2000);
    check("t7r_done", 32'(done), 32'h1);
    check("t7r_acc_cnt", 32'(acc_cnt), 32'd5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
